// File: rtl/vedic_mult_pkg.sv
// Shared types and helpers for the iterative Vedic multiplier.
// The magnitude helper works on a wide zero-extended operand; callers keep the low bits.
package vedic_mult_pkg;

    localparam int DIGIT_W  = 8;
    localparam int MAX_OP_W = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The low `width` bits of the result are |op|. For op = -2^(width-1) the result
    // is 2^(width-1), which is still representable as a width-bit unsigned value.
    function automatic logic [MAX_OP_W-1:0] magnitude(
        input logic [MAX_OP_W-1:0] op,
        input int unsigned         width,
        input logic                is_signed
    );
        if (is_signed && op[width-1]) begin
            return -op;
        end
        return op;
    endfunction

endpackage

// File: rtl/vedic_mult_8bit.sv
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier,
// built recursively from 2x2 and 4x4 blocks.
module vedic_mult_8bit (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        logic       t1;
        logic       t2;
        logic       t3;
        logic       c;
        t1   = x[1] & y[0];
        t2   = x[0] & y[1];
        t3   = x[1] & y[1];
        c    = t1 & t2;
        r[0] = x[0] & y[0];
        r[1] = t1 ^ t2;
        r[2] = t3 ^ c;
        r[3] = t3 & c;
        return r;
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        q0 = vedic2(x[1:0], y[1:0]);
        q1 = vedic2(x[3:2], y[1:0]);
        q2 = vedic2(x[1:0], y[3:2]);
        q3 = vedic2(x[3:2], y[3:2]);
        return 8'(q0) + (8'(q1) << 2) + (8'(q2) << 2) + (8'(q3) << 4);
    endfunction

    logic [7:0] p_ll;
    logic [7:0] p_hl;
    logic [7:0] p_lh;
    logic [7:0] p_hh;

    always_comb begin
        p_ll = vedic4(a_i[3:0], b_i[3:0]);
        p_hl = vedic4(a_i[7:4], b_i[3:0]);
        p_lh = vedic4(a_i[3:0], b_i[7:4]);
        p_hh = vedic4(a_i[7:4], b_i[7:4]);
        p_o  = 16'(p_ll) + (16'(p_hl) << 4) + (16'(p_lh) << 4) + (16'(p_hh) << 8);
    end

endmodule

// File: rtl/vedic_mult_iter.sv
// Iterative WIDTH x WIDTH multiplier: one 8x8 Vedic core reused over all digit pairs,
// with signed/unsigned mode and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand request
// MUL   | one digit pair multiplied and accumulated per cycle
// DONE  | result held on out until out_ready
module vedic_mult_iter
    import vedic_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);

    localparam int N      = WIDTH / DIGIT_W;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = 2 * WIDTH;

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W || WIDTH > MAX_OP_W / 2) begin : g_width_check
        $error("vedic_mult_iter: WIDTH must be a multiple of 8, at least 8 and at most 256");
    end

    state_t              state_q;
    logic [WIDTH-1:0]    ma_q;
    logic [WIDTH-1:0]    mb_q;
    logic                neg_q;
    logic [IDX_W-1:0]    i_q;
    logic [IDX_W-1:0]    j_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   out_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                busy_q;

    logic [WIDTH-1:0]    ma_d;
    logic [WIDTH-1:0]    mb_d;
    logic                neg_d;
    logic [DIGIT_W-1:0]  digit_a;
    logic [DIGIT_W-1:0]  digit_b;
    logic [2*DIGIT_W-1:0] pp;
    logic [PROD_W-1:0]   acc_d;
    logic [PROD_W-1:0]   res_d;
    logic                j_last;
    logic                i_last;

    vedic_mult_8bit u_core (
        .a_i (digit_a),
        .b_i (digit_b),
        .p_o (pp)
    );

    always_comb begin
        ma_d    = WIDTH'(magnitude(MAX_OP_W'(a), WIDTH, signed_mode));
        mb_d    = WIDTH'(magnitude(MAX_OP_W'(b), WIDTH, signed_mode));
        neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        digit_a = ma_q[DIGIT_W*i_q +: DIGIT_W];
        digit_b = mb_q[DIGIT_W*j_q +: DIGIT_W];
        acc_d   = acc_q + (PROD_W'(pp) << (DIGIT_W * (32'(i_q) + 32'(j_q))));
        // Final negation wraps mod 2^PROD_W, which is the two's-complement product.
        res_d   = neg_q ? -acc_d : acc_d;
        j_last  = (j_q == IDX_W'(N - 1));
        i_last  = (i_q == IDX_W'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ma_q        <= '0;
            mb_q        <= '0;
            neg_q       <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ma_q       <= ma_d;
                        mb_q       <= mb_d;
                        neg_q      <= neg_d;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    if (i_last && j_last) begin
                        out_q       <= res_d;
                        out_valid_q <= 1'b1;
                        i_q         <= '0;
                        j_q         <= '0;
                        state_q     <= DONE;
                    end else if (j_last) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_mult_iter.sv
// Bench for vedic_mult_iter: WIDTH=32 and WIDTH=8 instances against a cycle-level
// behavioural model whose products come from plain integer multiplication.
module tb_vedic_mult_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv32, s32, ordy32, irdy32, ov32, bsy32;
    logic [31:0] a32, b32;
    logic [63:0] o32;
    logic        iv8, s8, ordy8, irdy8, ov8, bsy8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;

    int checks = 0;
    int errors = 0;

    vedic_mult_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(irdy32), .a(a32), .b(b32),
        .signed_mode(s32), .out_valid(ov32), .out_ready(ordy32), .out(o32), .busy(bsy32)
    );

    vedic_mult_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(irdy8), .a(a8), .b(b8),
        .signed_mode(s8), .out_valid(ov8), .out_ready(ordy8), .out(o8), .busy(bsy8)
    );

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        if (w == 8) begin
            sa = s ? longint'($signed(a[7:0])) : longint'({24'b0, a[7:0]});
            sb = s ? longint'($signed(b[7:0])) : longint'({24'b0, b[7:0]});
            p  = 64'(sa * sb);
            return {48'b0, p[15:0]};
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = idle, 1 = multiplying (cycles left), 2 = holding a result.
    int          m_st[2]  = '{0, 0};
    int          m_cnt[2] = '{0, 0};
    logic [63:0] m_res[2] = '{64'd0, 64'd0};
    logic [63:0] m_out[2] = '{64'd0, 64'd0};
    logic        mv, ms, mr;
    logic [31:0] ma, mb;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mv = (k == 0) ? iv32 : iv8;
            ms = (k == 0) ? s32 : s8;
            mr = (k == 0) ? ordy32 : ordy8;
            ma = (k == 0) ? a32 : {24'b0, a8};
            mb = (k == 0) ? b32 : {24'b0, b8};
            if (rst) begin
                m_st[k]  = 0;
                m_out[k] = 64'd0;
            end else begin
                case (m_st[k])
                    0: if (mv) begin
                        m_res[k] = ref_prod(ma, mb, ms, (k == 0) ? 32 : 8);
                        m_cnt[k] = (k == 0) ? 16 : 1;
                        m_st[k]  = 1;
                    end
                    1: begin
                        m_cnt[k] = m_cnt[k] - 1;
                        if (m_cnt[k] == 0) begin
                            m_st[k]  = 2;
                            m_out[k] = m_res[k];
                        end
                    end
                    2: if (mr) m_st[k] = 0;
                    default: m_st[k] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready32",  64'(irdy32), 64'(m_st[0] == 0));
        chk("busy32",      64'(bsy32),  64'(m_st[0] != 0));
        chk("out_valid32", 64'(ov32),   64'(m_st[0] == 2));
        chk("out32",       o32,         m_out[0]);
        chk("in_ready8",   64'(irdy8),  64'(m_st[1] == 0));
        chk("busy8",       64'(bsy8),   64'(m_st[1] != 0));
        chk("out_valid8",  64'(ov8),    64'(m_st[1] == 2));
        chk("out8",        64'(o8),     {48'b0, m_out[1][15:0]});
    end

    task automatic drive(input int k, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        if (k == 0) begin
            iv32 = v; a32 = a; b32 = b; s32 = s;
        end else begin
            iv8 = v; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
        end
    endtask

    task automatic set_ordy(input int k, input logic v);
        if (k == 0) ordy32 = v;
        else        ordy8  = v;
    endtask

    function automatic logic ovk(input int k);
        return (k == 0) ? ov32 : ov8;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input bit junk, output int lat, output logic [63:0] res);
        bit got;
        @(negedge clk);
        drive(k, 1'b1, a, b, s);
        @(posedge clk);
        #1;
        drive(k, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ovk(k)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid of instance %0d never rose, required within 100 cycles", k);
        end
        res = (k == 0) ? o32 : {48'b0, o8};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive(k, junk, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        drive(k, junk, $urandom, $urandom, 1'($urandom_range(0, 1)));
        set_ordy(k, 1'b1);
        @(negedge clk);
        drive(k, 1'b0, $urandom, $urandom, 1'b0);
        set_ordy(k, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [63:0] res;
        logic [31:0] ra, rb;
        logic        rs;
        int          k;

        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
        ordy32 = 1'b0;
        ordy8  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(irdy32), 64'd1);
        chk("reset_out_valid", 64'(ov32), 64'd0);
        chk("reset_busy", 64'(bsy32), 64'd0);
        chk("reset_out", o32, 64'd0);
        rst = 1'b0;

        chk("model_pin_uu", ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32), 64'hFFFF_FFFE_0000_0001);
        chk("model_pin_s8", ref_prod(32'h80, 32'h7F, 1'b1, 8), 64'hC080);

        do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, lat, res);
        chk("uu_max", res, 64'hFFFF_FFFE_0000_0001);
        chk("latency32", 64'(lat), 64'd16);
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 0, 1'b0, lat, res);
        chk("s_m1x5", res, 64'hFFFF_FFFF_FFFF_FFFB);
        do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0, lat, res);
        chk("s_minx1", res, 64'hFFFF_FFFF_8000_0000);
        do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0, lat, res);
        chk("s_minxmin", res, 64'h4000_0000_0000_0000);

        do_op(0, 32'd100, 32'd200, 1'b0, 5, 1'b1, lat, res);
        chk("backpressure_res", res, 64'h4E20);
        chk("idle_after_release", 64'(irdy32), 64'd1);
        do_op(0, 32'd7, 32'd6, 1'b0, 0, 1'b0, lat, res);
        chk("after_bp_7x6", res, 64'h2A);

        @(negedge clk);
        drive(0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_out_valid", 64'(ov32), 64'd0);
        chk("midreset_in_ready", 64'(irdy32), 64'd1);
        chk("midreset_busy", 64'(bsy32), 64'd0);
        chk("midreset_out", o32, 64'd0);
        rst = 1'b0;
        do_op(0, 32'd3, 32'd4, 1'b0, 0, 1'b0, lat, res);
        chk("after_reset_3x4", res, 64'hC);
        chk("after_reset_latency", 64'(lat), 64'd16);

        do_op(1, 32'h0F, 32'h0F, 1'b0, 0, 1'b0, lat, res);
        chk("w8_0fx0f", res, 64'h00E1);
        chk("latency8", 64'(lat), 64'd1);
        do_op(1, 32'h80, 32'h7F, 1'b1, 1, 1'b1, lat, res);
        chk("w8_s80x7f", res, 64'hC080);
        do_op(1, 32'h80, 32'h7F, 1'b0, 0, 1'b0, lat, res);
        chk("w8_u80x7f", res, 64'h3F80);

        for (int n = 0; n < 45; n++) begin
            k  = (n % 3 == 0) ? 1 : 0;
            ra = pick_operand();
            rb = pick_operand();
            if (k == 1) begin
                ra = {24'b0, ra[31:24] ^ ra[7:0]};
                rb = {24'b0, rb[31:24] ^ rb[7:0]};
            end
            rs = 1'($urandom_range(0, 1));
            do_op(k, ra, rb, rs, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat, res);
            chk("rand_result", res, ref_prod(ra, rb, rs, (k == 0) ? 32 : 8));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
